// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared types and sizing helpers for the LED PWM driver
package led_pwm_pkg;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_COMMIT
    } pwm_state_e;

    function automatic int maxd_of(input int duty_w);
        return (1 << duty_w) - 1;
    endfunction

    function automatic int chan_w(input int num_leds);
        return (num_leds > 2) ? $clog2(num_leds) : 1;
    endfunction

    function automatic int sat_duty(input int duty, input int maxd);
        return (duty > maxd) ? maxd : duty;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - free-running divider producing a one-cycle tick every PRESCALE clocks
module pwm_prescaler #(
    parameter int PRESCALE = 781
) (
    input  logic clk50,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);
    // A held (cleared) divider never ticks, so downstream sees no stray frame event.
    assign tick = wrap && !clear;

    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (clear || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - per-channel PWM LED driver with frame-aligned double-buffered duties
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter  int NUM_LEDS = 6,
    parameter  int DUTY_W   = 6,
    parameter  int PRESCALE = 781,
    localparam int CW       = chan_w(NUM_LEDS)
) (
    input  logic                clk50,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CW-1:0]       in_chan,
    input  logic [DUTY_W-1:0]   in_duty,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] leds,
    output logic                frame_tick,
    output logic                chan_err
);

    localparam int MAXD = maxd_of(DUTY_W);
    localparam logic [DUTY_W-1:0] LAST_PHASE = DUTY_W'(MAXD - 1);

    pwm_state_e          state;
    logic                tick;
    logic                wr_fire;
    logic                chan_ok;
    logic [DUTY_W-1:0]   wr_duty;

    logic [DUTY_W-1:0]   phase_q, phase_d;
    logic [DUTY_W-1:0]   shadow_q [NUM_LEDS];
    logic [DUTY_W-1:0]   shadow_d [NUM_LEDS];
    logic [DUTY_W-1:0]   act_q    [NUM_LEDS];
    logic [DUTY_W-1:0]   act_d    [NUM_LEDS];
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                frame_tick_q, frame_tick_d;
    logic                chan_err_q, chan_err_d;

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk50(clk50),
        .rst_n(rst_n),
        .clear(!enable),
        .tick (tick)
    );

    always_comb begin
        state = ST_RUN;
        if (!enable) begin
            state = ST_STOP;
        end else if (tick && (phase_q == LAST_PHASE)) begin
            state = ST_COMMIT;
        end
    end

    // Writes are refused only in the commit cycle so they never race the shadow->active copy.
    assign in_ready = (state != ST_COMMIT);
    assign wr_fire  = in_valid && in_ready;
    assign chan_ok  = (32'(in_chan) < NUM_LEDS);
    assign wr_duty  = DUTY_W'(sat_duty(int'(in_duty), MAXD));

    always_comb begin
        phase_d      = phase_q;
        act_d        = act_q;
        shadow_d     = shadow_q;
        frame_tick_d = 1'b0;
        chan_err_d   = wr_fire && !chan_ok;
        leds_d       = '0;

        unique case (state)
            ST_STOP: begin
                phase_d = '0;
                act_d   = shadow_q;
            end
            ST_COMMIT: begin
                phase_d      = '0;
                act_d        = shadow_q;
                frame_tick_d = 1'b1;
            end
            default: begin
                if (tick) begin
                    phase_d = phase_q + DUTY_W'(1);
                end
            end
        endcase

        for (int i = 0; i < NUM_LEDS; i++) begin
            leds_d[i] = enable && (phase_q < act_q[i]);
            if (wr_fire && chan_ok && (in_chan == CW'(i))) begin
                shadow_d[i] = wr_duty;
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= '0;
            leds_q       <= '0;
            frame_tick_q <= 1'b0;
            chan_err_q   <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                shadow_q[i] <= '0;
                act_q[i]    <= '0;
            end
        end else begin
            phase_q      <= phase_d;
            leds_q       <= leds_d;
            frame_tick_q <= frame_tick_d;
            chan_err_q   <= chan_err_d;
            shadow_q     <= shadow_d;
            act_q        <= act_d;
        end
    end

    assign leds       = leds_q;
    assign frame_tick = frame_tick_q;
    assign chan_err   = chan_err_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - self-checking bench for led_pwm_driver against a cycle-position model
module tb_led_pwm_driver;

    localparam int N    = 6;
    localparam int DW   = 6;
    localparam int P    = 2;
    localparam int MAXD = 63;
    localparam int F    = MAXD * P;
    localparam int CW   = 3;

    logic          clk50    = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          enable   = 1'b0;
    logic [CW-1:0] in_chan  = '0;
    logic [DW-1:0] in_duty  = '0;
    logic          in_ready, frame_tick, chan_err;
    logic [N-1:0]  leds;

    int checks   = 0;
    int failures = 0;

    // Model: position within the frame in clock cycles, plus shadow/active duty tables.
    int           m_shadow [N];
    int           m_act    [N];
    int           m_pos;
    logic [N-1:0] m_leds;
    logic         m_ft, m_err;

    typedef struct {
        int   chan;
        int   duty;
        logic exp_err;
    } wr_vec_t;

    always #5 clk50 = ~clk50;

    led_pwm_driver #(
        .NUM_LEDS(N),
        .DUTY_W  (DW),
        .PRESCALE(P)
    ) dut (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_chan   (in_chan),
        .in_duty   (in_duty),
        .enable    (enable),
        .leds      (leds),
        .frame_tick(frame_tick),
        .chan_err  (chan_err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 0;
            m_act[i]    = 0;
        end
        m_pos  = 0;
        m_leds = '0;
        m_ft   = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic step();
        logic         bnd, rdy, acc;
        logic [N-1:0] nl;
        bnd = enable && (m_pos == F - 1);
        rdy = !bnd;
        check("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        for (int i = 0; i < N; i++) nl[i] = enable && ((m_pos / P) < m_act[i]);
        m_leds = nl;
        m_ft   = bnd;
        m_err  = acc && (in_chan >= N);
        for (int i = 0; i < N; i++) if (!enable || bnd) m_act[i] = m_shadow[i];
        if (acc && in_chan < N) m_shadow[in_chan] = (in_duty > MAXD) ? MAXD : int'(in_duty);
        m_pos = (!enable || bnd) ? 0 : m_pos + 1;
        @(posedge clk50);
        @(negedge clk50);
        check("leds", leds, m_leds);
        check("frame_tick", frame_tick, m_ft);
        check("chan_err", chan_err, m_err);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write(input int ch, input int duty);
        logic rdy;
        in_chan  = CW'(ch);
        in_duty  = DW'(duty);
        in_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            rdy = in_ready;
            step();
            if (rdy) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < F + 8 && !seen; k++) begin
            step();
            seen = frame_tick;
        end
        check(name, seen, 1'b1);
    endtask

    task automatic profile(input int ch, output int hi[N], output int first_low);
        for (int i = 0; i < N; i++) hi[i] = 0;
        first_low = -1;
        for (int k = 0; k < F; k++) begin
            step();
            in_valid = 1'b0;
            for (int i = 0; i < N; i++) if (leds[i]) hi[i]++;
            if (!leds[ch] && first_low < 0) first_low = k;
        end
        check("frame_period", frame_tick, 1'b1);
    endtask

    initial begin
        wr_vec_t      vecs [8];
        int           exp_hi [N];
        int           hi [N];
        int           fl;
        int           cnt;
        logic [N-1:0] any;

        vecs[0] = '{0, 16, 1'b0};
        vecs[1] = '{1,  5, 1'b0};
        vecs[2] = '{2, 63, 1'b0};
        vecs[3] = '{3,  0, 1'b0};
        vecs[4] = '{4, 33, 1'b0};
        vecs[5] = '{7, 40, 1'b1};
        vecs[6] = '{5,  1, 1'b0};
        vecs[7] = '{6, 12, 1'b1};

        model_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk50);
        check("rst_leds", leds, 0);
        check("rst_frame_tick", frame_tick, 0);
        check("rst_chan_err", chan_err, 0);
        rst_n = 1'b1;
        #1;
        check("rdy_after_rst", in_ready, 1);

        // Basic duty: 16 phases x 2 cycles on, the rest off, nothing else lit.
        write(0, 16);
        wait_tick("basic_tick");
        for (int r = 0; r < 2; r++) begin
            profile(0, hi, fl);
            check("basic_high_cycles", hi[0], 32);
            check("basic_first_low", fl, 32);
            for (int i = 1; i < N; i++) check("basic_other_off", hi[i], 0);
        end

        for (int i = 0; i < N; i++) exp_hi[i] = 0;
        foreach (vecs[v]) begin
            write(vecs[v].chan, vecs[v].duty);
            check("table_chan_err", chan_err, vecs[v].exp_err);
            if (!vecs[v].exp_err) exp_hi[vecs[v].chan] = vecs[v].duty * P;
        end
        wait_tick("table_tick");
        profile(0, hi, fl);
        for (int i = 0; i < N; i++) check("table_duty", hi[i], exp_hi[i]);

        for (int r = 0; r < 3; r++) begin
            profile(2, hi, fl);
            check("extreme_max_on", hi[2], F);
            check("extreme_zero_off", hi[3], 0);
        end

        write(7, 40);
        check("bad_chan_pulse", chan_err, 1);
        step();
        check("bad_chan_one_cycle", chan_err, 0);
        wait_tick("bad_tick");
        profile(0, hi, fl);
        for (int i = 0; i < N; i++) check("bad_chan_unchanged", hi[i], exp_hi[i]);

        // Boundary collision: request lands on the commit cycle and is taken one cycle later.
        cnt = 0;
        while (m_pos != F - 1 && cnt < F + 8) begin
            step();
            cnt++;
        end
        in_chan  = CW'(1);
        in_duty  = DW'(8);
        in_valid = 1'b1;
        check("collide_not_ready", in_ready, 0);
        step();
        check("collide_tick", frame_tick, 1);
        check("collide_ready_next", in_ready, 1);
        profile(1, hi, fl);
        check("collide_old_frame", hi[1], 5 * P);
        profile(1, hi, fl);
        check("collide_new_frame", hi[1], 8 * P);

        run(60);
        enable = 1'b0;
        step();
        check("disable_leds_off", leds, 0);
        run(5);
        enable = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3 * F; k++) begin
            step();
            cnt++;
            if (frame_tick) break;
        end
        check("reenable_full_frame", cnt, F);

        run(20);
        check("pre_reset_led2", leds[2], 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_leds", leds, 0);
        check("async_rst_frame_tick", frame_tick, 0);
        check("async_rst_chan_err", chan_err, 0);
        model_reset();
        @(negedge clk50);
        rst_n = 1'b1;
        any = '0;
        for (int k = 0; k < F + 4; k++) begin
            step();
            any |= leds;
        end
        check("post_reset_dark", any, 0);

        for (int k = 0; k < 1500; k++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_chan  = CW'($urandom_range(0, 7));
            in_duty  = DW'($urandom);
            if ($urandom_range(0, 199) == 0) enable = !enable;
            step();
        end
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
